// File: rtl/datapath_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pkg
// Shared constants for the multi-cycle datapath: the instruction period, the
// named phases at which the phase-latched registers load, and a clog2 helper
// that never returns less than one bit (used to size select/phase ports).
// No ports.
// -----------------------------------------------------------------------------
package datapath_pkg;

   // Cycles per instruction period for the whole datapath.
   localparam int DP_PERIOD = 32'd10;

   // Latch points within the instruction period.
   localparam int PH_MEM_DATA   = 32'd4;
   localparam int PH_FETCH_ADDR = 32'd8;
   localparam int PH_PC_UPDATE  = 32'd9;

   // $clog2 clamped to a minimum of one bit so a 1-entry range still gets a port.
   function automatic int clog2_min1(input int value);
      int bits;
      bits = $clog2(value);
      if (bits < 32'd1) begin
         return 32'd1;
      end else begin
         return bits;
      end
   endfunction

endpackage

// File: rtl/phase_counter.sv
// -----------------------------------------------------------------------------
// phase_counter
// Modulo-PERIOD phase counter shared by every phase-latched register of the
// datapath. Flags the edge on which the owning register must load.
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-low reset (phase -> 0)
//   stall     in   freeze the counter
//   resync    in   force phase to LATCH_PHASE and request a load (beats stall)
//   phase     out  registered phase value
//   load_now  out  combinational: the coming rising edge is a load edge
// -----------------------------------------------------------------------------
module phase_counter
   import datapath_pkg::*;
#(
   parameter int PERIOD      = DP_PERIOD,
   parameter int LATCH_PHASE = PH_FETCH_ADDR,
   localparam int PH_W       = clog2_min1(PERIOD)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            stall,
   input  logic            resync,
   output logic [PH_W-1:0] phase,
   output logic            load_now
);

   localparam logic [PH_W-1:0] PH_LAST  = PH_W'(PERIOD - 32'd1);
   localparam logic [PH_W-1:0] PH_LATCH = PH_W'(LATCH_PHASE);
   // A natural load happens on the edge that moves the counter onto
   // LATCH_PHASE, so the current phase is one behind it (wrapping for 0).
   localparam logic [PH_W-1:0] PH_PRE   =
      PH_W'((LATCH_PHASE == 32'd0) ? (PERIOD - 32'd1) : (LATCH_PHASE - 32'd1));

   generate
      if (PERIOD < 32'd2) begin : g_bad_period
         $error("phase_counter: PERIOD must be >= 2");
      end
      if ((LATCH_PHASE < 32'd0) || (LATCH_PHASE >= PERIOD)) begin : g_bad_latch
         $error("phase_counter: LATCH_PHASE must be in 0 .. PERIOD-1");
      end
   endgenerate

   logic [PH_W-1:0] r_phase;
   logic [PH_W-1:0] w_phase_next;
   logic            w_load_now;

   // Next-phase and load-edge decode: resync > stall > normal counting.
   always_comb begin
      w_phase_next = r_phase;
      w_load_now   = 1'b0;
      if (resync) begin
         w_phase_next = PH_LATCH;
         w_load_now   = 1'b1;
      end else if (stall) begin
         w_phase_next = r_phase;
         w_load_now   = 1'b0;
      end else begin
         if (r_phase == PH_LAST) begin
            w_phase_next = {PH_W{1'b0}};
         end else begin
            w_phase_next = r_phase + PH_W'(1'b1);
         end
         w_load_now = (r_phase == PH_PRE);
      end
   end

   // Phase register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_phase <= {PH_W{1'b0}};
      end else begin
         r_phase <= w_phase_next;
      end
   end

   assign phase    = r_phase;
   assign load_now = w_load_now;

endmodule

// File: rtl/phased_mux.sv
// -----------------------------------------------------------------------------
// phased_mux
// N-way registered multiplexer that updates its output only on the load edge
// of each instruction period (one programmable phase), with stall, resync,
// a one-cycle load strobe and an illegal-select flag.
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   stall        in   freeze phase and output
//   resync       in   immediate load, phase realigned to LATCH_PHASE
//   sel          in   input select, sampled on load edges only
//   data_in      in   flattened inputs, input i at [i*WIDTH +: WIDTH]
//   data_out     out  registered selected data
//   phase        out  current phase counter value
//   load_strobe  out  high for the cycle after a load edge
//   sel_err      out  high for the cycle after a load edge with sel >= NUM_INPUTS
// -----------------------------------------------------------------------------
module phased_mux
   import datapath_pkg::*;
#(
   parameter int               WIDTH       = 32'd32,
   parameter int               NUM_INPUTS  = 32'd2,
   parameter int               PERIOD      = DP_PERIOD,
   parameter int               LATCH_PHASE = PH_FETCH_ADDR,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
   localparam int              SEL_W       = clog2_min1(NUM_INPUTS),
   localparam int              PH_W        = clog2_min1(PERIOD)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        stall,
   input  logic                        resync,
   input  logic [SEL_W-1:0]            sel,
   input  logic [NUM_INPUTS*WIDTH-1:0] data_in,
   output logic [WIDTH-1:0]            data_out,
   output logic [PH_W-1:0]             phase,
   output logic                        load_strobe,
   output logic                        sel_err
);

   generate
      if (NUM_INPUTS < 32'd2) begin : g_bad_inputs
         $error("phased_mux: NUM_INPUTS must be >= 2");
      end
      if (PERIOD < 32'd2) begin : g_bad_period
         $error("phased_mux: PERIOD must be >= 2");
      end
      if ((LATCH_PHASE < 32'd0) || (LATCH_PHASE >= PERIOD)) begin : g_bad_latch
         $error("phased_mux: LATCH_PHASE must be in 0 .. PERIOD-1");
      end
   endgenerate

   logic             w_load_now;
   logic [PH_W-1:0]  w_phase;
   logic [WIDTH-1:0] w_inputs [NUM_INPUTS];
   logic             w_sel_ok;
   logic [WIDTH-1:0] w_sel_data;

   logic [WIDTH-1:0] r_data_out;
   logic             r_load_strobe;
   logic             r_sel_err;

   phase_counter #(
      .PERIOD      (PERIOD),
      .LATCH_PHASE (LATCH_PHASE)
   ) u_phase_counter (
      .clock    (clock),
      .reset    (reset),
      .stall    (stall),
      .resync   (resync),
      .phase    (w_phase),
      .load_now (w_load_now)
   );

   genvar g;
   generate
      for (g = 0; g < NUM_INPUTS; g++) begin : g_unpack
         assign w_inputs[g] = data_in[g*WIDTH +: WIDTH];
      end
   endgenerate

   // Select decode; an out-of-range select never indexes the input array.
   always_comb begin
      w_sel_ok   = (32'(sel) < NUM_INPUTS);
      w_sel_data = r_data_out;
      if (w_sel_ok) begin
         w_sel_data = w_inputs[sel];
      end else begin
         w_sel_data = r_data_out;
      end
   end

   // Output hold register with load strobe and illegal-select flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_data_out    <= RESET_VALUE;
         r_load_strobe <= 1'b0;
         r_sel_err     <= 1'b0;
      end else if (w_load_now) begin
         r_load_strobe <= 1'b1;
         if (w_sel_ok) begin
            r_data_out <= w_sel_data;
            r_sel_err  <= 1'b0;
         end else begin
            r_data_out <= r_data_out;
            r_sel_err  <= 1'b1;
         end
      end else begin
         r_data_out    <= r_data_out;
         r_load_strobe <= 1'b0;
         r_sel_err     <= 1'b0;
      end
   end

   assign data_out    = r_data_out;
   assign phase       = w_phase;
   assign load_strobe = r_load_strobe;
   assign sel_err     = r_sel_err;

endmodule

// File: tb/tb_phased_mux.sv
// -----------------------------------------------------------------------------
// tb_phased_mux
// Directed bench for phased_mux. Three instances share one clock:
//   dut_a  defaults (32-bit, 2 inputs, PERIOD 10, LATCH_PHASE 8)
//   dut_b  8-bit, 3 inputs, PERIOD 4, LATCH_PHASE 2 (illegal select)
//   dut_c  8-bit, 2 inputs, PERIOD 4, LATCH_PHASE 0, RESET_VALUE 0x5A
// Outputs are sampled 2 time units after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_phased_mux;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // ---- dut_a ----
   logic        a_rst, a_stall, a_resync;
   logic [0:0]  a_sel;
   logic [63:0] a_din;
   logic [31:0] a_dout;
   logic [3:0]  a_phase;
   logic        a_ls, a_se;

   // ---- dut_b ----
   logic        b_rst, b_stall, b_resync;
   logic [1:0]  b_sel;
   logic [23:0] b_din;
   logic [7:0]  b_dout;
   logic [1:0]  b_phase;
   logic        b_ls, b_se;

   // ---- dut_c ----
   logic        c_rst, c_stall, c_resync;
   logic [0:0]  c_sel;
   logic [15:0] c_din;
   logic [7:0]  c_dout;
   logic [1:0]  c_phase;
   logic        c_ls, c_se;

   phased_mux dut_a (
      .clock(clk), .reset(a_rst), .stall(a_stall), .resync(a_resync),
      .sel(a_sel), .data_in(a_din), .data_out(a_dout), .phase(a_phase),
      .load_strobe(a_ls), .sel_err(a_se)
   );

   phased_mux #(.WIDTH(8), .NUM_INPUTS(3), .PERIOD(4), .LATCH_PHASE(2)) dut_b (
      .clock(clk), .reset(b_rst), .stall(b_stall), .resync(b_resync),
      .sel(b_sel), .data_in(b_din), .data_out(b_dout), .phase(b_phase),
      .load_strobe(b_ls), .sel_err(b_se)
   );

   phased_mux #(.WIDTH(8), .NUM_INPUTS(2), .PERIOD(4), .LATCH_PHASE(0),
                .RESET_VALUE(8'h5A)) dut_c (
      .clock(clk), .reset(c_rst), .stall(c_stall), .resync(c_resync),
      .sel(c_sel), .data_in(c_din), .data_out(c_dout), .phase(c_phase),
      .load_strobe(c_ls), .sel_err(c_se)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   localparam logic [31:0] VA = 32'hAAAA_0000;
   localparam logic [31:0] VB = 32'hBBBB_0000;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      a_rst = 1'b0; a_stall = 1'b0; a_resync = 1'b0; a_sel = 1'b0; a_din = {VB, VA};
      b_rst = 1'b0; b_stall = 1'b0; b_resync = 1'b0; b_sel = 2'd0;
      b_din = {8'h33, 8'h22, 8'h11};
      c_rst = 1'b0; c_stall = 1'b0; c_resync = 1'b0; c_sel = 1'b0;
      c_din = {8'hC2, 8'hC1};

      repeat (2) @(posedge clk);
      #2;
      check("a_rst_dout",  a_dout,  64'd0);
      check("a_rst_phase", a_phase, 64'd0);
      check("a_rst_ls",    a_ls,    64'd0);
      check("a_rst_se",    a_se,    64'd0);

      // ---------------- first natural load at edge 8 ----------------
      a_rst = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         check("a_pre_phase", a_phase, k);
         check("a_pre_dout",  a_dout,  64'd0);
         check("a_pre_ls",    a_ls,    64'd0);
      end
      tick();
      check("a_l1_dout",  a_dout,  VA);
      check("a_l1_ls",    a_ls,    64'd1);
      check("a_l1_phase", a_phase, 64'd8);

      // ---------------- sel only sampled on the load edge (edge 18) -----
      a_sel = 1'b1;
      for (int k = 9; k <= 17; k++) begin
         tick();
         check("a_hold_dout", a_dout, VA);
         check("a_hold_ls",   a_ls,   64'd0);
         if (k >= 10 && k <= 16) begin
            a_sel = k[0];
         end else begin
            a_sel = 1'b1;
         end
      end
      tick();
      check("a_l2_dout",  a_dout,  VB);
      check("a_l2_ls",    a_ls,    64'd1);
      check("a_l2_phase", a_phase, 64'd8);

      // ---------------- stall 3 edges at phase 5 ----------------
      a_sel = 1'b0;
      repeat (7) tick();
      check("a_st_pre_phase", a_phase, 64'd5);
      a_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("a_st_phase", a_phase, 64'd5);
         check("a_st_ls",    a_ls,    64'd0);
         check("a_st_dout",  a_dout,  VB);
      end
      a_stall = 1'b0;
      tick();
      tick();
      check("a_st_p7_phase", a_phase, 64'd7);
      check("a_st_p7_ls",    a_ls,    64'd0);
      tick();
      check("a_st_load_dout",  a_dout,  VA);
      check("a_st_load_ls",    a_ls,    64'd1);
      check("a_st_load_phase", a_phase, 64'd8);

      // ---------------- resync pulse at phase 2 ----------------
      repeat (4) tick();
      check("a_rs_pre_phase", a_phase, 64'd2);
      a_resync = 1'b1; a_sel = 1'b1;
      tick();
      check("a_rs_phase", a_phase, 64'd8);
      check("a_rs_dout",  a_dout,  VB);
      check("a_rs_ls",    a_ls,    64'd1);
      a_resync = 1'b0; a_sel = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         check("a_rs_gap_ls", a_ls, 64'd0);
      end
      tick();
      check("a_rs_next_ls",    a_ls,    64'd1);
      check("a_rs_next_phase", a_phase, 64'd8);
      check("a_rs_next_dout",  a_dout,  VA);

      // ---------------- resync held together with stall ----------------
      repeat (2) tick();
      a_stall = 1'b1; a_resync = 1'b1; a_sel = 1'b1;
      tick();
      check("a_rss1_phase", a_phase, 64'd8);
      check("a_rss1_dout",  a_dout,  VB);
      check("a_rss1_ls",    a_ls,    64'd1);
      a_sel = 1'b0;
      tick();
      check("a_rss2_phase", a_phase, 64'd8);
      check("a_rss2_dout",  a_dout,  VA);
      check("a_rss2_ls",    a_ls,    64'd1);
      a_stall = 1'b0; a_resync = 1'b0; a_sel = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         check("a_rss_gap_ls", a_ls, 64'd0);
      end
      tick();
      check("a_rss_next_ls",   a_ls,   64'd1);
      check("a_rss_next_dout", a_dout, VB);

      // ---------------- async reset mid-period at phase 6 ----------------
      repeat (8) tick();
      check("a_ar_pre_phase", a_phase, 64'd6);
      #1 a_rst = 1'b0;
      #1;
      check("a_ar_dout",  a_dout,  64'd0);
      check("a_ar_phase", a_phase, 64'd0);
      #1 a_rst = 1'b1;
      a_sel = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         check("a_ar_gap_ls",   a_ls,   64'd0);
         check("a_ar_gap_dout", a_dout, 64'd0);
      end
      tick();
      check("a_ar_load_dout", a_dout, VA);
      check("a_ar_load_ls",   a_ls,   64'd1);

      // ---------------- dut_b: 3 inputs, illegal select ----------------
      check("b_rst_dout", b_dout, 64'd0);
      check("b_rst_se",   b_se,   64'd0);
      b_rst = 1'b1; b_sel = 2'd2;
      tick();
      check("b_e1_ls", b_ls, 64'd0);
      tick();
      check("b_e2_dout",  b_dout,  64'h33);
      check("b_e2_ls",    b_ls,    64'd1);
      check("b_e2_se",    b_se,    64'd0);
      check("b_e2_phase", b_phase, 64'd2);
      b_sel = 2'd3;
      repeat (4) tick();
      check("b_e6_dout", b_dout, 64'h33);
      check("b_e6_ls",   b_ls,   64'd1);
      check("b_e6_se",   b_se,   64'd1);
      b_sel = 2'd1;
      tick();
      check("b_e7_ls", b_ls, 64'd0);
      check("b_e7_se", b_se, 64'd0);
      repeat (3) tick();
      check("b_e10_dout", b_dout, 64'h22);
      check("b_e10_se",   b_se,   64'd0);

      // ---------------- dut_c: LATCH_PHASE 0, PERIOD 4 ----------------
      check("c_rst_dout", c_dout, 64'h5A);
      c_rst = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         logic [7:0] exp_d;
         tick();
         if (k < 4) begin
            exp_d = 8'h5A;
         end else if (k < 8) begin
            exp_d = 8'hC1;
         end else if (k < 12) begin
            exp_d = 8'hC2;
         end else begin
            exp_d = 8'hC3;
         end
         check("c_ls",    c_ls,    ((k % 4) == 0) ? 64'd1 : 64'd0);
         check("c_phase", c_phase, k % 4);
         check("c_dout",  c_dout,  exp_d);
         if (k == 4) begin
            c_sel = 1'b1;
         end
         if (k == 8) begin
            c_din = {8'hC3, 8'hC1};
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
